// File: rtl/line_window_feeder.sv
// Buffers one reference block (NUM_LINES+2 rows) plus its original block (NUM_LINES rows)
// and streams one three-row line window per beat. Define LINE_WINDOW_FEEDER_OVERLAP_EN for ping-pong load/stream.
module line_window_feeder #(
   parameter int NUM_LINES = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] cur_upper_pix,
   output logic [63:0] cur_middle_pix,
   output logic [63:0] cur_lower_pix,
   output logic [47:0] org_pix,
   output logic        out_first,
   output logic        out_last,
   output logic        busy
);

   localparam int REF_ROWS = NUM_LINES + 2;
   localparam int REF_AW   = $clog2(REF_ROWS);
   localparam int ORG_AW   = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
   localparam logic [3:0] REF_LAST  = 4'(NUM_LINES + 1);
   localparam logic [3:0] LINE_LAST = 4'(NUM_LINES - 1);

   logic [3:0]  beat_cnt, beat_cnt_nxt;
   logic [3:0]  line_cnt, line_cnt_nxt;
   logic [3:0]  mid_idx, low_idx;
   logic        accept, handshake;
   logic [63:0] rd_upper, rd_middle, rd_lower;
   logic [47:0] rd_org;

   assign mid_idx   = line_cnt + 4'd1;
   assign low_idx   = line_cnt + 4'd2;
   assign accept    = in_valid && in_ready;
   assign handshake = out_valid && out_ready;

`ifdef LINE_WINDOW_FEEDER_OVERLAP_EN
   typedef enum logic [1:0] {LOAD_REF, LOAD_ORG, LOAD_FULL} load_state_t;

   load_state_t load_state, load_state_nxt;
   logic        streaming, streaming_nxt;
   logic        wr_bank, wr_bank_nxt, rd_bank;
   logic        load_done, last_line;
   logic [63:0] ref_mem [2][REF_ROWS];
   logic [47:0] org_mem [2][NUM_LINES];

   // The stream side always reads the bank the loader is not filling.
   assign rd_bank   = ~wr_bank;
   assign in_ready  = !rst && (load_state != LOAD_FULL);
   assign out_valid = !rst && streaming;
   assign busy      = streaming || (load_state != LOAD_REF) || (beat_cnt != 4'd0);
   assign load_done = accept && (load_state == LOAD_ORG) && (beat_cnt == LINE_LAST);
   assign last_line = handshake && (line_cnt == LINE_LAST);

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         load_state <= LOAD_REF;
         beat_cnt   <= '0;
         line_cnt   <= '0;
         streaming  <= 1'b0;
         wr_bank    <= 1'b0;
      end else begin
         load_state <= load_state_nxt;
         beat_cnt   <= beat_cnt_nxt;
         line_cnt   <= line_cnt_nxt;
         streaming  <= streaming_nxt;
         wr_bank    <= wr_bank_nxt;
      end
   end

   always_comb begin
      // NOTE: every combinational output is defaulted first so no path can infer a latch.
      load_state_nxt = load_state;
      beat_cnt_nxt   = beat_cnt;
      line_cnt_nxt   = line_cnt;
      streaming_nxt  = streaming;
      wr_bank_nxt    = wr_bank;
      if (accept) begin
         case (load_state)
            LOAD_REF: begin
               if (beat_cnt == REF_LAST) begin
                  beat_cnt_nxt   = '0;
                  load_state_nxt = LOAD_ORG;
               end else begin
                  beat_cnt_nxt = beat_cnt + 4'd1;
               end
            end
            LOAD_ORG: begin
               if (beat_cnt == LINE_LAST) begin
                  beat_cnt_nxt   = '0;
                  load_state_nxt = LOAD_FULL;
               end else begin
                  beat_cnt_nxt = beat_cnt + 4'd1;
               end
            end
            default: ;
         endcase
      end
      if (handshake) line_cnt_nxt = last_line ? 4'd0 : line_cnt + 4'd1;
      // A complete bank is handed to the stream side as soon as the stream side is free.
      if ((!streaming || last_line) && (load_done || load_state == LOAD_FULL)) begin
         streaming_nxt  = 1'b1;
         wr_bank_nxt    = ~wr_bank;
         load_state_nxt = LOAD_REF;
      end else if (last_line) begin
         streaming_nxt = 1'b0;
      end
   end

   // NOTE: row storage is deliberately not reset; a bank is always fully written before it is read.
   always_ff @(posedge clk) begin
      if (accept) begin
         if (load_state == LOAD_REF) ref_mem[wr_bank][REF_AW'(beat_cnt)] <= in_data;
         else                        org_mem[wr_bank][ORG_AW'(beat_cnt)] <= in_data[55:8];
      end
   end

   assign rd_upper  = ref_mem[rd_bank][REF_AW'(line_cnt)];
   assign rd_middle = ref_mem[rd_bank][REF_AW'(mid_idx)];
   assign rd_lower  = ref_mem[rd_bank][REF_AW'(low_idx)];
   assign rd_org    = org_mem[rd_bank][ORG_AW'(line_cnt)];
`else
   typedef enum logic [1:0] {LOAD_REF, LOAD_ORG, STREAM} state_t;

   state_t      state, state_nxt;
   logic [63:0] ref_mem [REF_ROWS];
   logic [47:0] org_mem [NUM_LINES];

   assign in_ready  = !rst && (state != STREAM);
   assign out_valid = !rst && (state == STREAM);
   assign busy      = !((state == LOAD_REF) && (beat_cnt == 4'd0));

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= LOAD_REF;
         beat_cnt <= '0;
         line_cnt <= '0;
      end else begin
         state    <= state_nxt;
         beat_cnt <= beat_cnt_nxt;
         line_cnt <= line_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      beat_cnt_nxt = beat_cnt;
      line_cnt_nxt = line_cnt;
      case (state)
         LOAD_REF: begin
            if (accept) begin
               if (beat_cnt == REF_LAST) begin
                  beat_cnt_nxt = '0;
                  state_nxt    = LOAD_ORG;
               end else begin
                  beat_cnt_nxt = beat_cnt + 4'd1;
               end
            end
         end
         LOAD_ORG: begin
            if (accept) begin
               if (beat_cnt == LINE_LAST) begin
                  beat_cnt_nxt = '0;
                  line_cnt_nxt = '0;
                  state_nxt    = STREAM;
               end else begin
                  beat_cnt_nxt = beat_cnt + 4'd1;
               end
            end
         end
         STREAM: begin
            if (handshake) begin
               if (line_cnt == LINE_LAST) begin
                  line_cnt_nxt = '0;
                  state_nxt    = LOAD_REF;
               end else begin
                  line_cnt_nxt = line_cnt + 4'd1;
               end
            end
         end
         default: state_nxt = LOAD_REF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         if (state == LOAD_REF) ref_mem[REF_AW'(beat_cnt)] <= in_data;
         else                   org_mem[ORG_AW'(beat_cnt)] <= in_data[55:8];
      end
   end

   assign rd_upper  = ref_mem[REF_AW'(line_cnt)];
   assign rd_middle = ref_mem[REF_AW'(mid_idx)];
   assign rd_lower  = ref_mem[REF_AW'(low_idx)];
   assign rd_org    = org_mem[ORG_AW'(line_cnt)];
`endif

   // Window outputs read as zero whenever no line is being offered.
   assign cur_upper_pix  = out_valid ? rd_upper  : '0;
   assign cur_middle_pix = out_valid ? rd_middle : '0;
   assign cur_lower_pix  = out_valid ? rd_lower  : '0;
   assign org_pix        = out_valid ? rd_org    : '0;
   assign out_first      = out_valid && (line_cnt == 4'd0);
   assign out_last       = out_valid && (line_cnt == LINE_LAST);

endmodule

// File: tb/tb_line_window_feeder.sv
// Scoreboard bench for line_window_feeder: a block-level model predicts every line window,
// a negedge monitor pops and compares on each handshake.
module tb_line_window_feeder;

   localparam int N        = 6;
   localparam int REF_ROWS = N + 2;

   typedef struct packed {
      logic [63:0] upper;
      logic [63:0] middle;
      logic [63:0] lower;
      logic [47:0] org;
      logic        first;
      logic        last;
   } line_t;

   logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
   logic        out_first, out_last, busy;
   logic [63:0] in_data, cur_upper_pix, cur_middle_pix, cur_lower_pix;
   logic [47:0] org_pix;

   line_t       sb_q[$];
   logic [63:0] mdl_ref[REF_ROWS];
   logic [63:0] mdl_org[N];
   int          n_tests, n_fail, hs_count;
   bit          held_vld;
   line_t       held;
   bit          a_done, b_done;

   line_window_feeder #(.NUM_LINES(N)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .cur_upper_pix(cur_upper_pix), .cur_middle_pix(cur_middle_pix),
      .cur_lower_pix(cur_lower_pix), .org_pix(org_pix),
      .out_first(out_first), .out_last(out_last), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input bit ok, input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic summary();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
   endtask

   task automatic abort_tb(input string what);
      check(1'b0, what, 0, 0);
      summary();
      $finish;
   endtask

   // Line k of a block is ref rows k..k+2 plus the active pixels of org row k.
   function automatic line_t expect_line(input int k);
      line_t l;
      l.upper  = mdl_ref[k];
      l.middle = mdl_ref[k+1];
      l.lower  = mdl_ref[k+2];
      l.org    = mdl_org[k][55:8];
      l.first  = (k == 0);
      l.last   = (k == N - 1);
      return l;
   endfunction

   function automatic line_t dut_line();
      line_t l;
      l = '{cur_upper_pix, cur_middle_pix, cur_lower_pix, org_pix, out_first, out_last};
      return l;
   endfunction

   // Monitor: compares every accepted line, checks holds under backpressure and idle zeros.
   always @(negedge clk) begin
      line_t exp_l;
      if (rst) begin
         held_vld = 1'b0;
      end else begin
         if (held_vld)
            check(out_valid && (dut_line() == held), "hold_stable", dut_line(), held);
         if (out_valid && out_ready) begin
            hs_count++;
            if (sb_q.size() == 0) begin
               check(1'b0, "unexpected_line", dut_line(), 0);
            end else begin
               exp_l = sb_q.pop_front();
               check(dut_line() == exp_l, "line_window", dut_line(), exp_l);
            end
         end else if (!out_valid) begin
            check(dut_line() == '0, "idle_zero", dut_line(), 0);
         end
         held_vld = out_valid && !out_ready;
         held     = dut_line();
      end
   end

   task automatic fill_pattern(input logic [7:0] ref_base);
      for (int r = 0; r < REF_ROWS; r++) mdl_ref[r] = {8{ref_base + 8'(r)}};
      for (int k = 0; k < N; k++) mdl_org[k] = {8'h00, {6{8'hA0 + 8'(k)}}, 8'h00};
   endtask

   task automatic fill_random();
      for (int r = 0; r < REF_ROWS; r++) mdl_ref[r] = {$urandom, $urandom};
      for (int k = 0; k < N; k++) mdl_org[k] = {$urandom, $urandom};
   endtask

   // Called at posedge+1; returns at posedge+1 right after the beat is accepted.
   task automatic send_beat(input logic [63:0] d);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_data  = d;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 300) abort_tb("in_ready_timeout");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   task automatic send_block(input int gap_pct);
      for (int r = 0; r < REF_ROWS; r++) begin
         if ($urandom_range(99) < gap_pct) begin
            @(posedge clk);
            #1;
         end
         send_beat(mdl_ref[r]);
      end
      for (int k = 0; k < N; k++) send_beat(mdl_org[k]);
      for (int k = 0; k < N; k++) sb_q.push_back(expect_line(k));
   endtask

   // Drives out_ready until the scoreboard drains; optional stall, reset or blocked input.
   task automatic run_stream(input int pct, input int stall_at, input int stall_len,
                             input int rst_at, input bit block_in, output int cyc);
      int base, stall;
      base  = hs_count;
      stall = 0;
      cyc   = 0;
      forever begin
         if (sb_q.size() == 0) break;
         if (block_in) check(in_ready == 1'b0, "in_ready_blocked", in_ready, 0);
         if (rst_at >= 0 && hs_count - base == rst_at) begin
            rst       = 1'b1;
            out_ready = 1'b1;
            sb_q.delete();
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            check(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
            check(busy == 1'b0, "rst_busy", busy, 0);
            check(in_ready == 1'b1, "rst_in_ready", in_ready, 1);
            break;
         end
         if (stall_at >= 0 && hs_count - base == stall_at && stall < stall_len) begin
            out_ready = 1'b0;
            stall++;
         end else begin
            out_ready = ($urandom_range(99) < pct);
         end
         @(posedge clk);
         #1;
         cyc++;
         if (cyc > 500) abort_tb("stream_timeout");
      end
      if (block_in) in_valid = 1'b0;
   endtask

   initial begin
      int cyc;
      n_tests   = 0;
      n_fail    = 0;
      hs_count  = 0;
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_data   = 64'h0123_4567_89AB_CDEF;
      out_ready = 1'b0;

      // Reset held two cycles with in_valid high.
      @(negedge clk);
      check(in_ready == 1'b0, "reset_in_ready", in_ready, 0);
      check(out_valid == 1'b0, "reset_out_valid", out_valid, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check(in_ready == 1'b1, "post_reset_in_ready", in_ready, 1);
      check(busy == 1'b0, "post_reset_busy", busy, 0);
      check(dut_line() == '0, "post_reset_pixels", dut_line(), 0);
      @(posedge clk);
      #1;

      // Nominal patterned block, out_ready held high.
      fill_pattern(8'h10);
      send_block(0);
      check(out_valid && out_first, "first_line_latency", {out_valid, out_first}, 2'b11);
      run_stream(100, -1, 0, -1, 1'b0, cyc);
      check(cyc == N, "stream_cycles", cyc, N);
      @(negedge clk);
      check(in_ready == 1'b1, "in_ready_after_last", in_ready, 1);
      @(posedge clk);
      #1;

      // Backpressure: three stall cycles while line 2 is offered.
      fill_random();
      send_block(30);
      run_stream(100, 2, 3, -1, 1'b0, cyc);
      check(cyc == N + 3, "stall_cycles", cyc, N + 3);

`ifndef LINE_WINDOW_FEEDER_OVERLAP_EN
      // Input driven with junk throughout streaming must be refused.
      fill_random();
      send_block(0);
      in_valid = 1'b1;
      in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
      run_stream(70, -1, 0, -1, 1'b1, cyc);
      @(negedge clk);
      check(in_ready == 1'b1, "in_ready_after_block", in_ready, 1);
      check(busy == 1'b0, "no_junk_written", busy, 0);
      @(posedge clk);
      #1;
`endif

      // Reset at line 3, then a fresh block must load from ref row 0.
      fill_random();
      send_block(0);
      run_stream(100, -1, 0, 3, 1'b0, cyc);
      @(posedge clk);
      #1;
      fill_random();
      send_block(20);
      check(out_valid && out_first, "post_rst_latency", {out_valid, out_first}, 2'b11);
      run_stream(60, -1, 0, -1, 1'b0, cyc);

      // Random blocks with random backpressure.
      for (int b = 0; b < 4; b++) begin
         fill_random();
         send_block(25);
         run_stream(50, -1, 0, -1, 1'b0, cyc);
         @(posedge clk);
         #1;
      end

`ifdef LINE_WINDOW_FEEDER_OVERLAP_EN
      // Block B loads while block A streams with toggling out_ready.
      fill_random();
      send_block(0);
      fill_pattern(8'h50);
      for (int k = 0; k < N; k++) mdl_org[k] = {$urandom, $urandom};
      a_done = 1'b0;
      b_done = 1'b0;
      fork
         begin
            int n;
            for (int r = 0; r < REF_ROWS; r++) send_beat(mdl_ref[r]);
            for (int k = 0; k < N; k++) send_beat(mdl_org[k]);
            for (int k = 0; k < N; k++) sb_q.push_back(expect_line(k));
            b_done = 1'b1;
            n = 0;
            forever begin
               @(negedge clk);
               if (a_done) break;
               check(in_ready == 1'b0, "in_ready_bank_full", in_ready, 0);
               n++;
               if (n > 300) abort_tb("swap_timeout");
            end
         end
         begin
            int base, t;
            base = hs_count;
            t    = 0;
            forever begin
               if (hs_count - base == N) break;
               if (hs_count - base == N - 1) out_ready = b_done;
               else                          out_ready = t[0];
               @(posedge clk);
               #1;
               t++;
               if (t > 300) abort_tb("stream_a_timeout");
            end
            a_done = 1'b1;
            @(negedge clk);
            check(out_valid && out_first, "swap_no_gap", {out_valid, out_first}, 2'b11);
            @(posedge clk);
            #1;
         end
      join
      run_stream(100, -1, 0, -1, 1'b0, cyc);
`endif

      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check(sb_q.size() == 0, "scoreboard_drained", sb_q.size(), 0);
      check(out_valid == 1'b0, "final_idle", out_valid, 0);
      summary();
      $finish;
   end

endmodule

// File: doc/line_window_feeder.md
Name: line_window_feeder

Overview:
- Producer end of the per-line SAD interface: buffers one 8x8 reference block plus its 6x6 original block, then streams one line window per beat.
- Each beat carries three consecutive reference rows (upper/middle/lower) and the matching original row.
- The beat feeds the combinational fractional-interpolation/abs-diff line stage; a downstream SAD accumulator provides out_ready.

Parameters:
- NUM_LINES, 6, output lines per block. Reference rows = NUM_LINES+2; original rows = NUM_LINES. Legal range 1..14.

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  64  ref row (8 pix, pixel j at bits 8j+7:8j) or org row (6 pix in bits 55:8; bits 63:56 and 7:0 ignored)
- out_valid  out  1  line window valid
- out_ready  in  1  downstream accepts line
- cur_upper_pix  out  64  ref row k
- cur_middle_pix  out  64  ref row k+1
- cur_lower_pix  out  64  ref row k+2
- org_pix  out  48  org row k (maps to consumer org_pix[55:8])
- out_first  out  1  high with line k=0
- out_last  out  1  high with line k=NUM_LINES-1
- busy  out  1  high in any state except LOAD_REF with zero beats received

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values: in_ready=0 during the rst cycle and 1 from the first cycle after; out_valid=0, out_first=0, out_last=0, busy=0; all pixel outputs 0.
- Row storage contents are not reset.
- FSM states: LOAD_REF, LOAD_ORG, STREAM.
- LOAD_REF:
  - in_ready=1.
  - Each accepted beat writes ref row[beat_cnt].
  - After row NUM_LINES+1 is accepted, beat_cnt clears and the FSM enters LOAD_ORG.
- LOAD_ORG:
  - in_ready=1.
  - Each accepted beat writes in_data[55:8] to org row[beat_cnt].
  - After row NUM_LINES-1 is accepted, the FSM enters STREAM with line_cnt=0.
- STREAM:
  - in_ready=0; in_valid is ignored and nothing is written.
  - out_valid=1.
  - Outputs are muxed from storage by line_cnt: upper=ref[k], middle=ref[k+1], lower=ref[k+2], org=org[k].
  - On out_valid && out_ready: line_cnt increments.
  - On the handshake at k=NUM_LINES-1: line_cnt clears and the FSM enters LOAD_REF, so in_ready=1 in the next cycle.
- Latency: last org beat accepted in cycle N -> line 0 valid in cycle N+1. With out_ready held high, one line per cycle, no bubbles.
- Backpressure:
  - While out_valid && !out_ready, all out_* signals are held stable.
  - out_valid is never withdrawn once asserted, except by rst.
- Outputs outside STREAM: pixel outputs, out_first and out_last are forced to 0.
- Counters are 4 bits wide; beat_cnt never exceeds NUM_LINES+1. There is no wrap into unused storage.
- Reset mid-operation, in any state: next cycle is LOAD_REF with all counters 0. A partial block is discarded; no partial line is emitted.
- NUM_LINES=1: out_first and out_last are both high on the single line.

Optional Feature:
- Macro: LINE_WINDOW_FEEDER_OVERLAP_EN.
- When defined:
  - Storage is duplicated into two banks (ping-pong).
  - While STREAM reads bank A, in_ready stays 1 and incoming beats load bank B using the same ref-then-org order; load sub-state is tracked independently of the stream side.
  - When bank B is complete, in_ready drops until bank A finishes streaming.
  - If bank B is complete at the last-line handshake, the banks swap and line 0 of bank B is valid in the very next cycle (out_valid stays 1, out_first=1).
  - Otherwise STREAM exits and waits for bank B to complete, entering STREAM the cycle after its last org beat.
- When undefined: single bank, behaviour exactly as above.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, all pixel outputs 0, no rows written; in_ready=1 on the first cycle after release.
- Nominal, NUM_LINES=6, out_ready=1:
  - Stimulus: ref row r = {8{8'h10+r}}, org row k = {8'h00,{6{8'hA0+k}},8'h00}.
  - Required: line k upper={8{10+k}}, middle={8{11+k}}, lower={8{12+k}}, org_pix={6{A0+k}}.
  - out_first only on k=0, out_last only on k=5; line 0 appears the cycle after the 14th accepted beat; 6 consecutive valid cycles.
- Backpressure: out_ready=0 for 3 cycles at k=2 -> outputs hold line 2 values bit-exact; line 3 appears the cycle after out_ready returns to 1; total 6 handshakes, none skipped or repeated.
- Input blocked: drive in_valid=1 with 0xDEAD... throughout STREAM -> in_ready=0, stored rows unchanged (lines 3..5 still correct); in_ready=1 the cycle after the k=5 handshake.
- Reset mid-stream: assert rst at k=3 -> next cycle out_valid=0, busy=0; the following block loads from ref row 0 and streams correctly.
- Overlap (macro defined):
  - Stimulus: feed block B (ref bytes 0x50+r) continuously while block A streams with out_ready toggling.
  - Required: block B line 0 valid the cycle after the block A k=5 handshake, with out_first=1 and no out_valid gap.
  - Required: in_ready=0 after B's 14th beat until that swap.
